color_grid_ctrl: RTL and testbench

COLOR_GRID_CTRL -- requirements
Module: color_grid_ctrl

---
 rtl/color_grid_ctrl_pkg.sv | 33 +++
 rtl/color_grid_ctrl_btn_debounce.sv | 45 ++++
 rtl/color_grid_ctrl.sv | 136 +++++++++++++
 tb/tb_color_grid_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/color_grid_ctrl_pkg.sv
// Shared definitions for the 4x4 colour grid controller: colour codes, FSM states, grid geometry.
package color_grid_ctrl_pkg;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] BLUE  = 3'b001;
   localparam logic [2:0] WHITE = 3'b111;

   localparam int GRID_DIM = 4;
   localparam int CELLS    = GRID_DIM * GRID_DIM;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   // Cells are stored column-major from the bottom-right, so (0,0) lands on index 15.
   function automatic logic [3:0] cell_index(input logic [1:0] col, input logic [1:0] row);
      cell_index = 4'd15 - {col, 2'b00} - {2'b00, row};
   endfunction

   function automatic logic [1:0] step_sat(input logic [1:0] v, input logic dec, input logic inc);
      if (dec && !inc && (v != 2'd0)) begin
         step_sat = v - 2'd1;
      end else if (inc && !dec && (v != 2'd3)) begin
         step_sat = v + 2'd1;
      end else begin
         step_sat = v;
      end
   endfunction

endpackage

// File: rtl/color_grid_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, counting debouncer and rising-edge pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_r;
   logic             sync2_r;
   logic             level_r;
   logic             pulse_r;
   logic [CNT_W-1:0] cnt_r;

   // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         pulse_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
         pulse_r <= 1'b0;
         if (sync2_r == level_r) begin
            cnt_r <= '0;
         end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_r <= sync2_r;
            pulse_r <= sync2_r;
            cnt_r   <= '0;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   assign pulse = pulse_r;

endmodule

// File: rtl/color_grid_ctrl.sv
// 4x4 colour grid editor: debounced buttons move a cursor, cycle cell colours and clear the grid.
// Optional cursor blink is enabled by defining CURSOR_BLINK_EN.
module color_grid_ctrl
   import color_grid_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BLINK_HALF      = 12500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_sel,
   input  logic       btn_clr,
   input  logic [3:0] posicion,
   output logic [2:0] dirColor,
   output logic       busy
);

   logic       up_s, down_s, left_s, right_s, sel_s, clr_s;
   state_t     state_r, state_nxt_s;
   logic [3:0] clr_cnt_r, clr_cnt_nxt_s;
   logic [1:0] col_r, row_r, col_nxt_s, row_nxt_s;
   logic [3:0] cursor_idx_s;
   logic       we_s;
   logic [3:0] waddr_s;
   logic [2:0] wdata_s;
   logic [2:0] cell_r [CELLS];

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up    (.clk(clk), .rst(rst), .btn(btn_up),    .pulse(up_s));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down  (.clk(clk), .rst(rst), .btn(btn_down),  .pulse(down_s));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left  (.clk(clk), .rst(rst), .btn(btn_left),  .pulse(left_s));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (.clk(clk), .rst(rst), .btn(btn_right), .pulse(right_s));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel   (.clk(clk), .rst(rst), .btn(btn_sel),   .pulse(sel_s));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr   (.clk(clk), .rst(rst), .btn(btn_clr),   .pulse(clr_s));

   assign cursor_idx_s = cell_index(col_r, row_r);
   assign busy         = (state_r == ST_CLEAR);

   // Next state, cursor update and store write port; pulses arriving during CLEAR are simply dropped.
   always_comb begin
      state_nxt_s   = state_r;
      clr_cnt_nxt_s = clr_cnt_r;
      col_nxt_s     = col_r;
      row_nxt_s     = row_r;
      we_s          = 1'b0;
      waddr_s       = cursor_idx_s;
      wdata_s       = cell_r[cursor_idx_s] + 3'd1;
      case (state_r)
         ST_CLEAR: begin
            we_s          = 1'b1;
            waddr_s       = clr_cnt_r;
            wdata_s       = BLACK;
            clr_cnt_nxt_s = clr_cnt_r + 4'd1;
            if (clr_cnt_r == 4'd15) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         ST_IDLE: begin
            if (clr_s) begin
               state_nxt_s   = ST_CLEAR;
               clr_cnt_nxt_s = 4'd0;
            end else if (sel_s) begin
               we_s = 1'b1;
            end else begin
               row_nxt_s = step_sat(row_r, up_s, down_s);
               col_nxt_s = step_sat(col_r, left_s, right_s);
            end
         end
         default: begin
            state_nxt_s   = ST_CLEAR;
            clr_cnt_nxt_s = 4'd0;
         end
      endcase
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_CLEAR;
         clr_cnt_r <= 4'd0;
         col_r     <= 2'd0;
         row_r     <= 2'd0;
      end else begin
         state_r   <= state_nxt_s;
         clr_cnt_r <= clr_cnt_nxt_s;
         col_r     <= col_nxt_s;
         row_r     <= row_nxt_s;
      end
   end

   // Cell store; not reset, it is initialised by the CLEAR sweep instead.
   always_ff @(posedge clk) begin
      if (we_s && !rst) begin
         cell_r[waddr_s] <= wdata_s;
      end
   end

`ifdef CURSOR_BLINK_EN
   localparam int BLINK_W = $clog2(BLINK_HALF + 1);

   logic [BLINK_W-1:0] blink_cnt_r;
   logic               blink_phase_r;
   logic [2:0]         rd_s;

   // Free-running blink timebase.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_r   <= '0;
         blink_phase_r <= 1'b0;
      end else if (blink_cnt_r == BLINK_W'(BLINK_HALF - 1)) begin
         blink_cnt_r   <= '0;
         blink_phase_r <= ~blink_phase_r;
      end else begin
         blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
      end
   end

   // Zero-latency read port with cursor inversion during the blink phase.
   always_comb begin
      rd_s = cell_r[posicion];
      if (blink_phase_r && (posicion == cursor_idx_s)) begin
         dirColor = ~rd_s;
      end else begin
         dirColor = rd_s;
      end
   end
`else
   assign dirColor = cell_r[posicion];
`endif

endmodule

// File: tb/tb_color_grid_ctrl.sv
// Scoreboard bench for color_grid_ctrl: stimulus pushes expectations, a negedge monitor compares.
module tb_color_grid_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up, btn_down, btn_left, btn_right, btn_sel, btn_clr;
   logic [3:0] posicion;
   logic [2:0] dirColor;
   logic       busy;

   always #5 clk = ~clk;

   color_grid_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_HALF(8)) dut (
      .clk(clk), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .btn_sel(btn_sel), .btn_clr(btn_clr),
      .posicion(posicion), .dirColor(dirColor), .busy(busy)
   );

   typedef struct packed {
      logic       is_busy;
      logic [3:0] pos;
      logic [2:0] exp;
   } item_t;

   item_t q[$];
   int    total = 0;
   int    bad   = 0;

   // Reference model: grid as colour per (col,row), cursor as plain integers.
   int mgrid[4][4];
   int mcol, mrow;

   always @(negedge clk) begin : monitor
      item_t it;
      if (q.size() > 0) begin
         it = q.pop_front();
         total++;
         if (it.is_busy) begin
            if (busy !== it.exp[0]) begin
               bad++;
               $display("FAIL busy: got %b want %b at %0t", busy, it.exp[0], $time);
            end
         end else if (dirColor !== it.exp) begin
            bad++;
            $display("FAIL cell[%0d]: got %b want %b at %0t", it.pos, dirColor, it.exp, $time);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_busy(input logic b);
      item_t it;
      it.is_busy = 1'b1;
      it.pos     = 4'd0;
      it.exp     = {2'b00, b};
      q.push_back(it);
   endtask

   task automatic check_grid();
      item_t it;
      for (int p = 0; p < 16; p++) begin
         posicion   = p[3:0];
         it.is_busy = 1'b0;
         it.pos     = p[3:0];
         // index p = 15 - 4*col - row
         it.exp     = 3'(mgrid[(15 - p) / 4][(15 - p) % 4]);
         q.push_back(it);
         tick(1);
      end
   endtask

   task automatic model_clear();
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            mgrid[c][r] = 0;
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0:       btn_up    = v;
         1:       btn_down  = v;
         2:       btn_left  = v;
         3:       btn_right = v;
         4:       btn_sel   = v;
         5:       btn_clr   = v;
         default: ;
      endcase
   endtask

   task automatic press(input int b, input int hold);
      set_btn(b, 1'b1);
      tick(hold);
      set_btn(b, 1'b0);
      tick(12);
      case (b)
         0:       if (mrow > 0) mrow--;
         1:       if (mrow < 3) mrow++;
         2:       if (mcol > 0) mcol--;
         3:       if (mcol < 3) mcol++;
         4:       mgrid[mcol][mrow] = (mgrid[mcol][mrow] + 1) % 8;
         default: ;
      endcase
   endtask

   task automatic wait_busy(input logic v, input int budget);
      int n = 0;
      while (busy !== v && n < budget) begin
         tick(1);
         n++;
      end
      total++;
      if (busy !== v) begin
         bad++;
         $display("FAIL wait_busy: got %b want %b within %0d cycles", busy, v, budget);
      end
   endtask

   task automatic expect_clear_after_rst();
      for (int i = 0; i < 16; i++) begin
         exp_busy(1'b1);
         tick(1);
      end
      exp_busy(1'b0);
      tick(1);
   endtask

   initial begin
      #500000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      btn_sel = 1'b0; btn_clr = 1'b0;
      posicion = 4'd0;
      mcol = 0; mrow = 0;
      model_clear();

      // single-cycle reset, then a 16-cycle clear sweep
      @(posedge clk);
      #1 rst = 1'b0;
      expect_clear_after_rst();
      check_grid();

      // long hold gives one increment, eight more presses wrap back
      press(4, 50);
      check_grid();
      repeat (8) press(4, 8);
      check_grid();

      // saturating moves to (3,1), then select
      repeat (5) press(3, 8);
      press(1, 8);
      press(4, 8);
      check_grid();

      // short glitch on up must not move the cursor
      btn_up = 1'b1;
      tick(2);
      btn_up = 1'b0;
      tick(12);
      press(4, 8);
      check_grid();

      // opposing horizontal moves cancel, vertical still applies
      btn_left = 1'b1; btn_right = 1'b1; btn_up = 1'b1;
      tick(8);
      btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0;
      tick(12);
      if (mrow > 0) mrow--;
      press(4, 8);
      check_grid();

      // sel outranks a simultaneous move
      btn_sel = 1'b1; btn_left = 1'b1;
      tick(8);
      btn_sel = 1'b0; btn_left = 1'b0;
      tick(12);
      mgrid[mcol][mrow] = (mgrid[mcol][mrow] + 1) % 8;
      check_grid();

      // random button walk
      repeat (40) press($urandom_range(0, 4), $urandom_range(5, 10));
      check_grid();

      // clear with a select press landing while busy
      btn_clr = 1'b1;
      tick(6);
      btn_clr = 1'b0;
      btn_sel = 1'b1;
      tick(6);
      btn_sel = 1'b0;
      wait_busy(1'b1, 20);
      wait_busy(1'b0, 40);
      tick(12);
      model_clear();
      check_grid();
      press(4, 8);
      check_grid();

      // reset in the middle of a clear restarts the whole sweep
      press(3, 6);
      btn_clr = 1'b1;
      tick(6);
      btn_clr = 1'b0;
      wait_busy(1'b1, 20);
      tick(7);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      expect_clear_after_rst();
      mcol = 0; mrow = 0;
      model_clear();
      check_grid();
      press(4, 8);
      check_grid();

`ifdef CURSOR_BLINK_EN
      begin
         item_t it;
         int    n;
         repeat (3) press(4, 8);
         posicion = 4'd15;
         n = 0;
         while (dirColor !== 3'b011 && n < 40) begin tick(1); n++; end
         while (dirColor !== 3'b100 && n < 40) begin tick(1); n++; end
         total++;
         if (n >= 40) begin
            bad++;
            $display("FAIL blink_sync: no phase change seen, got %b", dirColor);
         end
         for (int k = 0; k < 24; k++) begin
            it.is_busy = 1'b0;
            it.pos     = 4'd15;
            it.exp     = (((k / 8) % 2) == 0) ? 3'b100 : 3'b011;
            q.push_back(it);
            tick(1);
         end
      end
`endif

      tick(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
